// File: rtl/ascon_ctrl.sv
// Sequencing controller for the Ascon-128 permutation/XOR datapath: walks one AEAD
// encryption through init, AD absorption, PT encryption and finalisation.
module ascon_ctrl #(
  parameter logic [3:0] ROUND_A_START = 4'd0,
  parameter logic [3:0] ROUND_B_START = 4'd6
) (
  input  logic       clock_i,
  input  logic       resetb_i,
  input  logic       start_i,
  input  logic       ad_present_i,
  input  logic       block_valid_i,
  input  logic       block_last_i,
  output logic       block_ready_o,
  output logic       enable_o,
  output logic       input_mode_o,
  output logic [3:0] round_o,
  output logic [1:0] bypass_xor_begin_o,
  output logic [1:0] bypass_xor_end_o,
  output logic       cipher_en_o,
  output logic       tag_valid_o,
  output logic       busy_o
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_INIT    = 3'd1;
  localparam logic [2:0] S_WAIT_AD = 3'd2;
  localparam logic [2:0] S_AD_PERM = 3'd3;
  localparam logic [2:0] S_WAIT_PT = 3'd4;
  localparam logic [2:0] S_PT_PERM = 3'd5;
  localparam logic [2:0] S_FINAL   = 3'd6;
  localparam logic [2:0] S_DONE    = 3'd7;
  localparam logic [3:0] RC_LAST   = 4'd11;

  logic [2:0] state, state_nxt;
  logic [3:0] rc, rc_nxt;
  logic       ad_r, ad_nxt;
  logic       last_r, last_nxt;
  logic       accept;
  logic       rc_done;

  assign accept  = block_valid_i & block_ready_o;
  assign rc_done = (rc == RC_LAST);

  // Permutation states count up to round 11 and leave without wrapping the counter.
  always_comb begin
    state_nxt = state;
    rc_nxt    = rc;
    ad_nxt    = ad_r;
    last_nxt  = last_r;
    case (state)
      S_IDLE: begin
        if (start_i) begin
          state_nxt = S_INIT;
          rc_nxt    = ROUND_A_START;
          ad_nxt    = ad_present_i;
        end
      end
      S_INIT: begin
        if (rc_done) state_nxt = ad_r ? S_WAIT_AD : S_WAIT_PT;
        else         rc_nxt    = rc + 4'd1;
      end
      S_WAIT_AD: begin
        if (accept) begin
          state_nxt = S_AD_PERM;
          rc_nxt    = ROUND_B_START;
          last_nxt  = block_last_i;
        end
      end
      S_AD_PERM: begin
        if (rc_done) state_nxt = last_r ? S_WAIT_PT : S_WAIT_AD;
        else         rc_nxt    = rc + 4'd1;
      end
      S_WAIT_PT: begin
        if (accept) begin
          state_nxt = block_last_i ? S_FINAL : S_PT_PERM;
          rc_nxt    = block_last_i ? ROUND_A_START : ROUND_B_START;
        end
      end
      S_PT_PERM: begin
        if (rc_done) state_nxt = S_WAIT_PT;
        else         rc_nxt    = rc + 4'd1;
      end
      S_FINAL: begin
        if (rc_done) state_nxt = S_DONE;
        else         rc_nxt    = rc + 4'd1;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (!resetb_i) begin
      state  <= S_IDLE;
      rc     <= 4'd0;
      ad_r   <= 1'b0;
      last_r <= 1'b0;
    end else begin
      state  <= state_nxt;
      rc     <= rc_nxt;
      ad_r   <= ad_nxt;
      last_r <= last_nxt;
    end
  end

  // Moore output decode; round_o always shows the counter so WAIT states hold it.
  always_comb begin
    block_ready_o      = 1'b0;
    enable_o           = 1'b0;
    input_mode_o       = 1'b0;
    round_o            = rc;
    bypass_xor_begin_o = 2'b00;
    bypass_xor_end_o   = 2'b00;
    cipher_en_o        = 1'b0;
    tag_valid_o        = 1'b0;
    busy_o             = (state != S_IDLE);
    case (state)
      S_INIT: begin
        enable_o     = 1'b1;
        input_mode_o = (rc == ROUND_A_START);
        if (rc_done) bypass_xor_end_o = ad_r ? 2'b01 : 2'b11;
      end
      S_WAIT_AD, S_WAIT_PT: block_ready_o = 1'b1;
      S_AD_PERM: begin
        enable_o = 1'b1;
        if (rc == ROUND_B_START) bypass_xor_begin_o = 2'b01;
        if (rc_done)             bypass_xor_end_o   = last_r ? 2'b10 : 2'b00;
      end
      S_PT_PERM: begin
        enable_o = 1'b1;
        if (rc == ROUND_B_START) begin
          bypass_xor_begin_o = 2'b01;
          cipher_en_o        = 1'b1;
        end
      end
      S_FINAL: begin
        enable_o = 1'b1;
        if (rc == ROUND_A_START) begin
          bypass_xor_begin_o = 2'b11;
          cipher_en_o        = 1'b1;
        end
        if (rc_done) bypass_xor_end_o = 2'b01;
      end
      S_DONE:  tag_valid_o = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ascon_ctrl.sv
// Bench for ascon_ctrl: builds the expected per-cycle trace of whole messages from
// the phase rules, then replays the inputs and compares every cycle.
module tb_ascon_ctrl;

  logic       clk = 1'b0;
  logic       resetb = 1'b0;
  logic       start = 1'b0, ad_present = 1'b0, bvalid = 1'b0, blast = 1'b0;
  logic       bready, en, mode, cen, tag, busy;
  logic [3:0] rnd;
  logic [1:0] xb, xe;

  int n_cmp = 0;
  int n_err = 0;

  ascon_ctrl dut (
    .clock_i(clk), .resetb_i(resetb), .start_i(start), .ad_present_i(ad_present),
    .block_valid_i(bvalid), .block_last_i(blast), .block_ready_o(bready),
    .enable_o(en), .input_mode_o(mode), .round_o(rnd),
    .bypass_xor_begin_o(xb), .bypass_xor_end_o(xe), .cipher_en_o(cen),
    .tag_valid_o(tag), .busy_o(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        st, adp, bv, bl;
    logic [13:0] exp;  // {ready,en,mode,round[3:0],xb[1:0],xe[1:0],cen,tag,busy}
  } cyc_t;

  cyc_t sched[$];
  int   last_rnd = 0;
  int   total_stall;
  bit   noise;

  function automatic logic [13:0] act_vec();
    return {bready, en, mode, rnd, xb, xe, cen, tag, busy};
  endfunction

  function automatic logic rb();
    return noise ? 1'($urandom_range(0, 1)) : 1'b0;
  endfunction

  task automatic add(input logic st, adp, bv, bl, rdy, e, md, input int r,
                     input logic [1:0] b, x, input logic c, t, bs);
    cyc_t cy;
    cy.st = st; cy.adp = adp; cy.bv = bv; cy.bl = bl;
    cy.exp = {rdy, e, md, 4'(r), b, x, c, t, bs};
    sched.push_back(cy);
  endtask

  task automatic add_wait(input int stall, input logic lastblk);
    int s;
    s = (stall < 0) ? int'($urandom_range(0, 3)) : stall;
    total_stall += s;
    for (int k = 0; k < s; k++) add(rb(), rb(), 1'b0, rb(), 1, 0, 0, 11, 2'b00, 2'b00, 0, 0, 1);
    add(rb(), rb(), 1'b1, lastblk, 1, 0, 0, 11, 2'b00, 2'b00, 0, 0, 1);
  endtask

  // Expected trace of one message: IDLE start cycle, INIT, AD/PT blocks, FINAL, DONE, IDLE.
  task automatic build(input int na, input int np, input int stall, input bit start_in_done);
    sched.delete();
    total_stall = 0;
    add(1'b1, na > 0, rb(), rb(), 0, 0, 0, last_rnd, 2'b00, 2'b00, 0, 0, 0);
    for (int r = 0; r < 12; r++)
      add(rb(), rb(), rb(), rb(), 0, 1, r == 0, r, 2'b00,
          (r == 11) ? ((na > 0) ? 2'b01 : 2'b11) : 2'b00, 0, 0, 1);
    for (int i = 0; i < na; i++) begin
      add_wait(stall, i == na - 1);
      for (int r = 6; r < 12; r++)
        add(rb(), rb(), rb(), rb(), 0, 1, 0, r, (r == 6) ? 2'b01 : 2'b00,
            (r == 11 && i == na - 1) ? 2'b10 : 2'b00, 0, 0, 1);
    end
    for (int j = 0; j < np; j++) begin
      add_wait(stall, j == np - 1);
      if (j < np - 1) begin
        for (int r = 6; r < 12; r++)
          add(rb(), rb(), rb(), rb(), 0, 1, 0, r, (r == 6) ? 2'b01 : 2'b00, 2'b00, r == 6, 0, 1);
      end else begin
        for (int r = 0; r < 12; r++)
          add(rb(), rb(), rb(), rb(), 0, 1, 0, r, (r == 0) ? 2'b11 : 2'b00,
              (r == 11) ? 2'b01 : 2'b00, r == 0, 0, 1);
      end
    end
    add(start_in_done ? 1'b1 : rb(), rb(), rb(), rb(), 0, 0, 0, 11, 2'b00, 2'b00, 0, 1, 1);
    add(1'b0, rb(), rb(), rb(), 0, 0, 0, 11, 2'b00, 2'b00, 0, 0, 0);
    last_rnd = 11;
  endtask

  task automatic drive(input cyc_t cy);
    start = cy.st; ad_present = cy.adp; bvalid = cy.bv; blast = cy.bl;
  endtask

  task automatic test_reset();
    resetb = 1'b0;
    for (int i = 0; i < 3; i++) begin
      start = 1'($urandom_range(0, 1)); ad_present = 1'($urandom_range(0, 1));
      bvalid = 1'($urandom_range(0, 1)); blast = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (i > 0) begin
        n_cmp++;
        if (act_vec() !== 14'd0) begin
          n_err++;
          $display("FAIL reset_outputs cycle %0d: got %b, want %b", i, act_vec(), 14'd0);
        end
      end
      @(posedge clk); #1;
    end
    resetb = 1'b1; start = 0; ad_present = 0; bvalid = 0; blast = 0;
    last_rnd = 0;
  endtask

  task automatic test_message(input string name, input int na, input int np, input int stall,
                              input bit nz, input bit start_in_done);
    int ncen, ntag, tag_idx, want_lat;
    noise = nz;
    build(na, np, stall, start_in_done);
    ncen = 0; ntag = 0; tag_idx = -1;
    for (int i = 0; i < sched.size(); i++) begin
      drive(sched[i]);
      @(negedge clk);
      n_cmp++;
      if (act_vec() !== sched[i].exp) begin
        n_err++;
        $display("FAIL %s cycle %0d: got %b, want %b", name, i, act_vec(), sched[i].exp);
      end
      if (cen) ncen++;
      if (tag) begin ntag++; tag_idx = i; end
      @(posedge clk); #1;
    end
    start = 0; bvalid = 0; blast = 0;
    want_lat = 12 + na * 7 + (np - 1) * 7 + 13 + 1 + total_stall;
    n_cmp++;
    if (ncen !== np) begin
      n_err++; $display("FAIL %s cipher_pulses: got %0d, want %0d", name, ncen, np);
    end
    n_cmp++;
    if (ntag !== 1) begin
      n_err++; $display("FAIL %s tag_pulses: got %0d, want 1", name, ntag);
    end
    n_cmp++;
    if (tag_idx !== want_lat) begin
      n_err++; $display("FAIL %s start_to_tag: got %0d, want %0d", name, tag_idx, want_lat);
    end
  endtask

  // Reset while FINAL shows round 5, then confirm silence afterwards.
  task automatic test_reset_mid();
    noise = 0;
    build(0, 1, 0, 0);
    for (int i = 0; i < 20; i++) begin
      drive(sched[i]);
      if (i == 19) resetb = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (act_vec() !== sched[i].exp) begin
        n_err++;
        $display("FAIL reset_mid_pre cycle %0d: got %b, want %b", i, act_vec(), sched[i].exp);
      end
      @(posedge clk); #1;
    end
    resetb = 1'b1; start = 0; bvalid = 0; blast = 0;
    last_rnd = 0;
    @(negedge clk);
    n_cmp++;
    if (act_vec() !== 14'd0) begin
      n_err++; $display("FAIL reset_mid_idle: got %b, want %b", act_vec(), 14'd0);
    end
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({tag, busy, en} !== 3'b000) begin
        n_err++; $display("FAIL reset_mid_quiet cycle %0d: got %b, want 000", i, {tag, busy, en});
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_no_ad();       test_message("no_ad_single_pt", 0, 1, 0, 0, 0); endtask
  task automatic test_ad_pt();       test_message("ad2_pt2", 2, 2, 0, 0, 0);          endtask
  task automatic test_stall();       test_message("stall5", 2, 1, 5, 0, 0);           endtask
  task automatic test_spurious();    test_message("spurious", 2, 2, 1, 1, 0);         endtask
  task automatic test_back_to_back();
    test_message("b2b_first", 1, 1, 0, 0, 1);
    test_message("b2b_second", 0, 2, 0, 0, 1);
  endtask
  task automatic test_random();
    for (int m = 0; m < 12; m++)
      test_message("random", int'($urandom_range(0, 3)), int'($urandom_range(1, 3)), -1, 1, 0);
  endtask

  initial begin
    @(posedge clk); #1;
    test_reset();
    test_no_ad();
    test_ad_pt();
    test_stall();
    test_spurious();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
